mkio_transmitter: RTL and testbench
===================================

Name: mkio_transmitter

Overview:
- MIL-STD-1553 (MKIO) word transmitter. It sits directly downstream of the terminal control block, which supplies tx_data, tx_cd and the tx_ready strobe and watches tx_busy.
- It serialises one 16-bit word into a Manchester II bi-phase frame: 3-bit-time sync, 16 data bits MSB first, then an odd parity bit.
- It drives the differential bus transceiver inputs.
- A single-entry holding register lets words go out back-to-back with no inter-word gap.

Parameters:
- HALF_BIT, 8, clk cycles per half bit time. Default gives 1 Mbit/s at 16 MHz. Must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tx_ready  in  1  one-cycle strobe: capture tx_data/tx_cd into the holding register
- tx_data  in  16  word to send
- tx_cd  in  1  sync type: 0 = command/status sync, 1 = data sync
- tx_busy  out  1  holding register occupied; tx_ready ignored while high
- tx_active  out  1  frame currently on the line
- tx_p  out  1  transceiver positive drive
- tx_n  out  1  transceiver negative drive
- tx_en  out  1  transceiver enable (inhibit when low)
- word_done  out  1  one-cycle pulse on the last cycle of each frame's parity bit
- overrun  out  1  one-cycle pulse when tx_ready arrives while tx_busy is high

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, holding register empty, FSM in IDLE, counters 0.
- Holding register:
  - tx_ready with tx_busy=0 at edge N: hold_data<=tx_data, hold_cd<=tx_cd, tx_busy=1 from N+1.
  - tx_ready with tx_busy=1: word dropped, overrun pulses in the next cycle, holding contents unchanged.
- Load rule: the shifter loads from the holding register, clearing tx_busy in the same edge, when either:
  - the FSM is in IDLE, or
  - the FSM is on the final cycle of PARITY.
- Latency: tx_ready at edge N in IDLE → load at N+1 → first sync half-bit on the line from N+2. tx_busy is high for exactly 1 cycle in this case.
- Parity: computed at load. parity = ~^data, so the 17 bits always hold an odd number of ones.
- Half-bit timer: counts 0..HALF_BIT-1. A half-bit ends when the timer reaches HALF_BIT-1. A half-bit counter (6 bits) counts half-bits within the current state.
- FSM states:
  - IDLE: tx_p=tx_n=tx_en=tx_active=0. Go to SYNC on load.
  - SYNC: 6 half-bits.
    - cd=0: line high for 3, then low for 3.
    - cd=1: line low for 3, then high for 3.
    - Then go to DATA.
  - DATA: 32 half-bits, bit 15 first. Logic 1 = high then low; logic 0 = low then high. Then go to PARITY.
  - PARITY: 2 half-bits, same encoding as data.
    - At the end: word_done pulses.
    - If the holding register is full, load and go to SYNC with no idle cycle.
    - Otherwise go to IDLE.
- Line drive:
  - In all non-IDLE states: tx_en=1, tx_active=1, tx_p=level, tx_n=~level.
  - tx_p and tx_n are never both 1. Outputs are registered and glitch-free.
- Frame length: exactly 40*HALF_BIT clk cycles. Back-to-back frames are contiguous, with tx_en held high throughout.
- Simultaneous tx_ready and load in the same cycle: the load takes the old holding contents. The new word is then captured because the slot is freed in that edge. tx_busy stays 1 and no overrun occurs.
- tx_ready while shifting with an empty holding register: accepted normally. The current frame is not disturbed.
- Reset mid-frame: line goes to 0 immediately and the holding word is discarded. After release, nothing is sent until a new tx_ready arrives.

Test Plan:
- HALF_BIT=8, tx_ready with tx_data=16'h0C23, tx_cd=0 → line high 24 clk, low 24 clk, then bits 0000_1100_0010_0011 as Manchester, parity 0. tx_en high exactly 320 clk. word_done pulses once, at clk 320 of the frame.
- tx_data=16'hFFFF, tx_cd=1 → sync low 24 clk then high 24 clk; 16 "10" half-bit pairs; parity 1 (high then low).
- Back-to-back: send 16'h1234, then tx_ready 16'hABCD, tx_cd=1 at clk 100 of the first frame → no gap, tx_en continuously high for 640 clk. Second sync starts low. tx_busy stays high from clk 101 until the first frame's final parity cycle.
- Overrun: word A in shift, word B held, tx_ready word C → overrun pulses one cycle. A then B are transmitted, C is never transmitted.
- Reset asserted at clk 150 of a frame with a word held → tx_p/tx_n/tx_en/tx_busy drop to 0 asynchronously. After release, the line stays idle for 1000 clk with no tx_ready.
- Idle-to-first-edge latency: tx_ready at edge N → tx_en rises at edge N+2, tx_busy is high only during cycle N+1.

Source files
------------

// File: rtl/mkio_transmitter.sv
// MIL-STD-1553 word transmitter: Manchester II framing of sync, 16 data bits and odd parity,
// with a single-entry holding register so that frames can go out back-to-back.
module mkio_transmitter #(
    parameter int unsigned HALF_BIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_cd,
    output logic        tx_busy,
    output logic        tx_active,
    output logic        tx_p,
    output logic        tx_n,
    output logic        tx_en,
    output logic        word_done,
    output logic        overrun
);

    localparam int unsigned TMR_W  = (HALF_BIT > 2) ? $clog2(HALF_BIT) : 1;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

    state_t              state, state_nxt;
    logic [TMR_W-1:0]    tmr, tmr_nxt;
    logic [CNT_W-1:0]    hcnt, hcnt_nxt;
    logic [DATA_W-1:0]   hold_data;
    logic                hold_cd;
    logic [DATA_W:0]     shreg;
    logic                frame_cd;
    logic                half_end;
    logic                last_parity;
    logic                load;
    logic                accept;
    logic                level_c;
    logic                active_c;

    assign half_end    = (tmr == TMR_W'(HALF_BIT - 1));
    assign last_parity = (state == PARITY) && half_end && (hcnt == CNT_W'(1));
    assign load        = tx_busy && ((state == IDLE) || last_parity);
    // A load frees the slot in the same edge, so a coincident strobe is still accepted.
    assign accept      = tx_ready && (!tx_busy || load);
    assign active_c    = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            tmr   <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            hcnt  <= hcnt_nxt;
        end
    end

    // Next state, half-bit timing and the line level for the current half-bit.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = half_end ? '0 : tmr + TMR_W'(1);
        hcnt_nxt  = half_end ? hcnt + CNT_W'(1) : hcnt;
        level_c   = 1'b0;
        unique case (state)
            IDLE: begin
                tmr_nxt  = '0;
                hcnt_nxt = '0;
                if (load) state_nxt = SYNC;
            end
            SYNC: begin
                level_c = frame_cd ? (hcnt >= CNT_W'(3)) : (hcnt < CNT_W'(3));
                if (half_end && hcnt == CNT_W'(5)) begin
                    state_nxt = DATA;
                    hcnt_nxt  = '0;
                end
            end
            DATA: begin
                level_c = shreg[DATA_W] ^ hcnt[0];
                if (half_end && hcnt == CNT_W'(31)) begin
                    state_nxt = PARITY;
                    hcnt_nxt  = '0;
                end
            end
            PARITY: begin
                level_c = shreg[DATA_W] ^ hcnt[0];
                if (last_parity) begin
                    hcnt_nxt  = '0;
                    state_nxt = load ? SYNC : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding register and overrun detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_data <= '0;
            hold_cd   <= 1'b0;
            tx_busy   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                hold_data <= tx_data;
                hold_cd   <= tx_cd;
            end
            tx_busy <= accept ? 1'b1 : (load ? 1'b0 : tx_busy);
            overrun <= tx_ready && tx_busy && !load;
        end
    end

    // Shifter: data MSB first with odd parity appended at load time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            frame_cd <= 1'b0;
        end else if (load) begin
            shreg    <= {hold_data, ~^hold_data};
            frame_cd <= hold_cd;
        end else if (state == DATA && half_end && hcnt[0]) begin
            shreg <= {shreg[DATA_W-1:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_en     <= 1'b0;
            tx_active <= 1'b0;
            tx_p      <= 1'b0;
            tx_n      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            tx_en     <= active_c;
            tx_active <= active_c;
            tx_p      <= active_c && level_c;
            tx_n      <= active_c && !level_c;
            word_done <= last_parity;
        end
    end

endmodule

// File: tb/tb_mkio_transmitter.sv
// Directed bench for mkio_transmitter: frame patterns, latency, back-to-back, overrun and reset.
module tb_mkio_transmitter;

    localparam int HB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_busy, tx_active, tx_p, tx_n, tx_en, word_done, overrun;

    int checks = 0;
    int errors = 0;

    mkio_transmitter #(.HALF_BIT(HB)) dut (
        .clk(clk), .reset(reset), .tx_ready(tx_ready), .tx_data(tx_data), .tx_cd(tx_cd),
        .tx_busy(tx_busy), .tx_active(tx_active), .tx_p(tx_p), .tx_n(tx_n), .tx_en(tx_en),
        .word_done(word_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        cd;
        logic [39:0] pat;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe one word from idle and check the two-cycle start latency.
    task automatic send(input logic [15:0] d, input logic cd);
        tx_ready = 1'b1; tx_data = d; tx_cd = cd;
        tick();
        tx_ready = 1'b0;
        chk("lat_busy_n1", 80'(tx_busy), 80'd1);
        chk("lat_en_n1", 80'(tx_en), 80'd0);
        tick();
        chk("lat_busy_n2", 80'(tx_busy), 80'd0);
        tick();
        chk("lat_en_n2", 80'(tx_en), 80'd1);
    endtask

    // Record nhalf half-bits starting at the current (first active) cycle, with two optional strobes.
    task automatic capture(input int nhalf,
                           input int i1_at, input logic [15:0] i1_d, input logic i1_c,
                           input int i2_at, input logic [15:0] i2_d, input logic i2_c,
                           output logic [79:0] pat, output int line_err,
                           output int wd_cnt, output int wd_first,
                           output int ov_cnt, output int ov_first,
                           output int busy_cnt, output int busy_first, output int busy_last);
        logic prev_p;
        pat = '0; line_err = 0; wd_cnt = 0; wd_first = -1; ov_cnt = 0; ov_first = -1;
        busy_cnt = 0; busy_first = -1; busy_last = -1; prev_p = 1'b0;
        for (int c = 0; c < nhalf * HB; c++) begin
            if (tx_en !== 1'b1 || tx_active !== 1'b1 || tx_p === tx_n) line_err++;
            if ((c % HB) != 0 && tx_p !== prev_p) line_err++;
            prev_p = tx_p;
            if ((c % HB) == HB / 2) pat[nhalf - 1 - c / HB] = tx_p;
            if (word_done === 1'b1) begin
                wd_cnt++;
                if (wd_first < 0) wd_first = c;
            end
            if (overrun === 1'b1) begin
                ov_cnt++;
                if (ov_first < 0) ov_first = c;
            end
            if (tx_busy === 1'b1) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (c == i1_at) begin
                tx_ready = 1'b1; tx_data = i1_d; tx_cd = i1_c;
            end else if (c == i2_at) begin
                tx_ready = 1'b1; tx_data = i2_d; tx_cd = i2_c;
            end else begin
                tx_ready = 1'b0;
            end
            tick();
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [79:0] pat;
        int line_err, wd_cnt, wd_first, ov_cnt, ov_first, busy_cnt, busy_first, busy_last;
        int seen;

        vecs[0] = '{16'h0C23, 1'b0, 40'hE156956569};
        vecs[1] = '{16'hFFFF, 1'b1, 40'h1EAAAAAAAA};
        vecs[2] = '{16'h0000, 1'b0, 40'hE155555556};
        vecs[3] = '{16'hABCD, 1'b1, 40'h1E666A969A};

        reset = 1'b0; tx_ready = 1'b0; tx_data = '0; tx_cd = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 80'(tx_busy), 80'd0);
        chk("rst_active", 80'(tx_active), 80'd0);
        chk("rst_p", 80'(tx_p), 80'd0);
        chk("rst_n", 80'(tx_n), 80'd0);
        chk("rst_en", 80'(tx_en), 80'd0);
        chk("rst_wd", 80'(word_done), 80'd0);
        chk("rst_ov", 80'(overrun), 80'd0);
        reset = 1'b1;
        repeat (3) tick();

        // Single frames from the vector table.
        for (int v = 0; v < 4; v++) begin
            send(vecs[v].data, vecs[v].cd);
            capture(40, -1, '0, 1'b0, -1, '0, 1'b0, pat, line_err, wd_cnt, wd_first,
                    ov_cnt, ov_first, busy_cnt, busy_first, busy_last);
            chk($sformatf("frame_pat_%0d", v), pat, 80'(vecs[v].pat));
            chk($sformatf("frame_line_%0d", v), 80'(line_err), 80'd0);
            chk($sformatf("frame_wd_cnt_%0d", v), 80'(wd_cnt), 80'd1);
            chk($sformatf("frame_wd_pos_%0d", v), 80'(wd_first), 80'd319);
            chk($sformatf("frame_en_end_%0d", v), 80'(tx_en), 80'd0);
            repeat (5) tick();
        end

        // Back-to-back: second word strobed at clk 100 of the first frame.
        send(16'h1234, 1'b0);
        capture(80, 99, 16'hABCD, 1'b1, -1, '0, 1'b0, pat, line_err, wd_cnt, wd_first,
                ov_cnt, ov_first, busy_cnt, busy_first, busy_last);
        chk("b2b_pat", pat, {40'hE159656995, 40'h1E666A969A});
        chk("b2b_line", 80'(line_err), 80'd0);
        chk("b2b_wd_cnt", 80'(wd_cnt), 80'd2);
        chk("b2b_busy_first", 80'(busy_first), 80'd100);
        chk("b2b_busy_last", 80'(busy_last), 80'd318);
        chk("b2b_busy_cnt", 80'(busy_cnt), 80'd219);
        chk("b2b_ov_cnt", 80'(ov_cnt), 80'd0);
        chk("b2b_en_end", 80'(tx_en), 80'd0);
        repeat (5) tick();

        // Overrun: A shifting, B held, C dropped.
        send(16'h0000, 1'b0);
        capture(80, 50, 16'hFFFF, 1'b1, 60, 16'h0C23, 1'b0, pat, line_err, wd_cnt, wd_first,
                ov_cnt, ov_first, busy_cnt, busy_first, busy_last);
        chk("ovr_pat", pat, {40'hE155555556, 40'h1EAAAAAAAA});
        chk("ovr_line", 80'(line_err), 80'd0);
        chk("ovr_cnt", 80'(ov_cnt), 80'd1);
        chk("ovr_pos", 80'(ov_first), 80'd61);
        chk("ovr_wd_cnt", 80'(wd_cnt), 80'd2);
        seen = 0;
        for (int c = 0; c < 400; c++) begin
            if (tx_en !== 1'b0 || tx_busy !== 1'b0) seen++;
            tick();
        end
        chk("ovr_c_not_sent", 80'(seen), 80'd0);

        // Reset at clk 150 of a frame with a word held.
        send(16'h1234, 1'b0);
        for (int c = 0; c < 150; c++) begin
            if (c == 20) begin
                tx_ready = 1'b1; tx_data = 16'hABCD; tx_cd = 1'b1;
            end else begin
                tx_ready = 1'b0;
            end
            tick();
        end
        chk("mid_busy", 80'(tx_busy), 80'd1);
        chk("mid_en", 80'(tx_en), 80'd1);
        reset = 1'b0;
        #1;
        chk("arst_p", 80'(tx_p), 80'd0);
        chk("arst_n", 80'(tx_n), 80'd0);
        chk("arst_en", 80'(tx_en), 80'd0);
        chk("arst_busy", 80'(tx_busy), 80'd0);
        chk("arst_active", 80'(tx_active), 80'd0);
        repeat (2) tick();
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (tx_en !== 1'b0 || tx_p !== 1'b0 || tx_n !== 1'b0 || tx_busy !== 1'b0) seen++;
        end
        chk("post_rst_idle", 80'(seen), 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
